mem_req_arbiter: RTL

Arbitrates two SRAM-like request ports onto the single shared SRAM-like memory port feeding the AXI bridge. The two ports are instruction fetch (IF stage) and data access (EXE stage load/store). The block grants one request per cycle, with data having priority and each grant locked until accepted. It records the source of every accepted request in an in-order tracking FIFO, and uses that FIFO to route each returning `data_ok`/`rdata` back to the port that issued the request.

---
 rtl/mem_req_arbiter_pkg.sv | 23 ++
 rtl/mem_req_arbiter_src_fifo.sv | 61 ++++++
 rtl/mem_req_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_req_arbiter_pkg
// Shared source encodings and lock-state type for the memory request arbiter.
// Revision: 1.0
// ============================================================================
package mem_req_arbiter_pkg;

    localparam logic c_SRC_INST = 1'b0;
    localparam logic c_SRC_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_st_t;

    function automatic lock_st_t lock_of(input logic src);
        return (src == c_SRC_DATA) ? LOCK_DATA : LOCK_INST;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_req_arbiter_src_fifo.sv
`default_nettype none
// ============================================================================
// src_fifo
// 1-bit in-order FIFO recording the source of every accepted memory request.
// Revision: 1.0
// ============================================================================
module src_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DEPTH-1:0]   r_mem;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // Full is taken from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// mem_req_arbiter
// Data-priority arbiter of IF/EXE SRAM-like ports onto one memory port, with
// grant locking and in-order response routing.
// Revision: 1.0
// ============================================================================
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    lock_st_t r_lock_st;
    lock_st_t w_lock_nxt;
    logic     w_grant_inst;
    logic     w_grant_data;
    logic     w_fifo_full;
    logic     w_fifo_empty;
    logic     w_head;
    logic     w_push;
    logic     w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_st <= IDLE;
        end else begin
            r_lock_st <= w_lock_nxt;
        end
    end

    // A locked grant ignores the other port so a stalled request is never
    // pre-empted before the memory accepts it.
    always_comb begin
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        w_lock_nxt   = r_lock_st;
        if (!reset) begin
            case (r_lock_st)
                IDLE: begin
                    if (!w_fifo_full && data_req) begin
                        w_grant_data = 1'b1;
                    end else if (!w_fifo_full && inst_req) begin
                        w_grant_inst = 1'b1;
                    end
                    if ((w_grant_data || w_grant_inst) && !mem_addr_ok) begin
                        w_lock_nxt = lock_of(w_grant_data);
                    end
                end
                LOCK_INST: begin
                    w_grant_inst = 1'b1;
                    if (mem_addr_ok) w_lock_nxt = IDLE;
                end
                LOCK_DATA: begin
                    w_grant_data = 1'b1;
                    if (mem_addr_ok) w_lock_nxt = IDLE;
                end
                default: w_lock_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req   = w_grant_inst | w_grant_data;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'd0;
        mem_wstrb = 4'd0;
        mem_wdata = 32'd0;
        if (w_grant_data) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wstrb = data_wstrb;
            mem_wdata = data_wdata;
        end else if (w_grant_inst) begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_addr  = inst_addr;
            mem_wstrb = inst_wstrb;
            mem_wdata = inst_wdata;
        end
    end

    assign inst_addr_ok = mem_addr_ok & mem_req & w_grant_inst;
    assign data_addr_ok = mem_addr_ok & mem_req & w_grant_data;

    assign w_push = mem_req & mem_addr_ok;
    // A response with nothing outstanding is a protocol error and is dropped.
    assign w_pop  = mem_data_ok & ~w_fifo_empty & ~reset;

    assign inst_data_ok = w_pop & (w_head == c_SRC_INST);
    assign data_data_ok = w_pop & (w_head == c_SRC_DATA);
    assign inst_rdata   = reset ? 32'd0 : mem_rdata;
    assign data_rdata   = reset ? 32'd0 : mem_rdata;

    src_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_src_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_grant_data),
        .dout  (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

endmodule
`default_nettype wire
